// File: rtl/addsub_arb_pkg.sv
// Shared parameters and payload types for the round-robin add/sub arbiter.
package addsub_arb_pkg;

  localparam int unsigned WIDTH   = 25;
  localparam int unsigned NUM_REQ = 4;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W = id_w(NUM_REQ);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [ID_W-1:0]  id;
  } rsp_t;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester and response bundle; master = requesters/consumer, slave = arbiter.
interface addsub_arbiter_if
  import addsub_arb_pkg::*;
#(
  parameter int unsigned P_WIDTH   = WIDTH,
  parameter int unsigned P_NUM_REQ = NUM_REQ,
  parameter int unsigned P_ID_W    = id_w(P_NUM_REQ)
);
  logic [P_NUM_REQ-1:0]         req_valid;
  logic [P_NUM_REQ-1:0]         req_ready;
  logic [P_NUM_REQ*P_WIDTH-1:0] req_a;
  logic [P_NUM_REQ*P_WIDTH-1:0] req_b;
  logic [P_NUM_REQ-1:0]         req_sub;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [P_WIDTH-1:0]           rsp_sum;
  logic                         rsp_cout;
  logic [P_ID_W-1:0]            rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/addsub_arbiter_cla.sv
// Generate/propagate carry-lookahead adder with carry-in and carry-out.
module CarryLookaheadAdder #(
  parameter int unsigned WIDTH = 25
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign sum  = w_p ^ w_c[WIDTH-1:0];
  assign cout = w_c[WIDTH];
endmodule

// File: rtl/addsub_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest set request at or cyclically after ptr,
// found by masking the low half of a doubled request vector.
module rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  localparam int unsigned DW = 2 * N;

  logic [DW-1:0] w_dbl;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_masked;
  logic [DW-1:0] w_low;

  assign w_dbl    = {req, req};
  assign w_mask   = ~((DW'(1) << ptr) - DW'(1));
  assign w_masked = w_dbl & w_mask;
  // Isolate the lowest set bit, then fold both halves back onto N lanes.
  assign w_low    = w_masked & (~w_masked + DW'(1));
  assign grant    = w_low[N-1:0] | w_low[DW-1:N];
  assign any      = |req;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant[k]) gnt_idx = gnt_idx | IW'(k);
    end
  end
endmodule

// File: rtl/addsub_arbiter.sv
// Shares one add/sub datapath among NUM_REQ requesters with round-robin grant
// and a single registered response slot that can load while draining.
module addsub_arbiter
  import addsub_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  addsub_arbiter_if.slave   bus
);
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_hs;
  op_t                w_op;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [ID_W-1:0]    w_ptr_next;

  logic [ID_W-1:0]    r_rr_ptr;
  slot_state_t        r_state;
  rsp_t               r_rsp;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req     (bus.req_valid),
    .ptr     (r_rr_ptr),
    .grant   (w_grant),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  always_comb begin
    w_op = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_op.a   = bus.req_a[k*WIDTH +: WIDTH];
        w_op.b   = bus.req_b[k*WIDTH +: WIDTH];
        w_op.sub = bus.req_sub[k];
      end
    end
  end

  CarryLookaheadAdder #(.WIDTH(WIDTH)) u_adder (
    .a    (w_op.a),
    .b    (w_op.b ^ {WIDTH{w_op.sub}}),
    .cin  (w_op.sub),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_accept   = (r_state == SLOT_EMPTY) || bus.rsp_ready;
  assign w_hs       = w_any && w_accept;
  assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  // Ready is forced low while reset is held, even though the slot reads EMPTY.
  assign bus.req_ready = w_grant & {NUM_REQ{w_accept & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SLOT_EMPTY;
      r_rsp    <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (w_hs) begin
            r_state  <= SLOT_FULL;
            r_rsp    <= '{sum: w_sum, cout: w_cout, id: w_gnt_idx};
            r_rr_ptr <= w_ptr_next;
          end
        end
        SLOT_FULL: begin
          if (w_hs) begin
            r_rsp    <= '{sum: w_sum, cout: w_cout, id: w_gnt_idx};
            r_rr_ptr <= w_ptr_next;
          end else if (bus.rsp_ready) begin
            r_state  <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign bus.rsp_valid = (r_state == SLOT_FULL);
  assign bus.rsp_sum   = r_rsp.sum;
  assign bus.rsp_cout  = r_rsp.cout;
  assign bus.rsp_id    = r_rsp.id;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: arithmetic, round-robin order, backpressure, reset.
module tb_addsub_arbiter;
  import addsub_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  addsub_arbiter_if bus_if ();

  addsub_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic sub);
    bus_if.req_valid[i]          = v;
    bus_if.req_a[i*WIDTH +: WIDTH] = a;
    bus_if.req_b[i*WIDTH +: WIDTH] = b;
    bus_if.req_sub[i]            = sub;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [WIDTH-1:0] s,
                           input logic c, input logic [ID_W-1:0] id);
    check({tag, ".valid"}, 32'(bus_if.rsp_valid), 32'(v));
    check({tag, ".sum"},   32'(bus_if.rsp_sum),   32'(s));
    check({tag, ".cout"},  32'(bus_if.rsp_cout),  32'(c));
    check({tag, ".id"},    32'(bus_if.rsp_id),    32'(id));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    bus_if.rsp_ready = 1'b0;
    clear_reqs();
    #2 rst_n = 1'b0;
    #1;
    check_rsp("reset", 1'b0, '0, 1'b0, '0);
    check("reset.ready", 32'(bus_if.req_ready), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Basic subtract without borrow
    tick();
    bus_if.rsp_ready = 1'b1;
    set_req(0, 1'b1, 25'd5, 25'd3, 1'b1);
    #1 check("sub0.ready", 32'(bus_if.req_ready), 32'h1);
    tick();
    clear_reqs();
    check_rsp("sub0", 1'b1, 25'd2, 1'b1, 2'd0);

    // Borrow, then carry-out wrap on add
    set_req(2, 1'b1, 25'd3, 25'd5, 1'b1);
    #1 check("sub2.ready", 32'(bus_if.req_ready), 32'h4);
    tick();
    check_rsp("sub2", 1'b1, 25'h1FFFFFE, 1'b0, 2'd2);
    set_req(2, 1'b1, 25'h1FFFFFF, 25'd1, 1'b0);
    tick();
    clear_reqs();
    check_rsp("add2wrap", 1'b1, 25'd0, 1'b1, 2'd2);

    // Lone req3 granted twice in a row; pointer wraps to 0
    set_req(3, 1'b1, 25'd10, 25'd20, 1'b0);
    #1 check("r3a.ready", 32'(bus_if.req_ready), 32'h8);
    tick();
    check_rsp("r3a", 1'b1, 25'd30, 1'b0, 2'd3);
    set_req(3, 1'b1, 25'd7, 25'd1, 1'b1);
    #1 check("r3b.ready", 32'(bus_if.req_ready), 32'h8);
    tick();
    clear_reqs();
    check_rsp("r3b", 1'b1, 25'd6, 1'b1, 2'd3);
    tick();
    check_rsp("drain", 1'b0, 25'd6, 1'b1, 2'd3);

    // All requesters valid: grants rotate 0,1,2,3,0,1 with no bubbles
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, WIDTH'(100 + i), WIDTH'(i), 1'b0);
    #1 check("rr.ready0", 32'(bus_if.req_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_rsp($sformatf("rr%0d", k), 1'b1, WIDTH'(100 + 2 * (k % 4)), 1'b0, ID_W'(k % 4));
      if (k < 5) check($sformatf("rr%0d.ready", k), 32'(bus_if.req_ready), 32'(1 << ((k + 1) % 4)));
    end

    // Backpressure: slot FULL, consumer stalls, req1 must wait
    clear_reqs();
    bus_if.rsp_ready = 1'b0;
    set_req(1, 1'b1, 25'd50, 25'd8, 1'b1);
    #1 check("bp.ready", 32'(bus_if.req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_rsp($sformatf("bp%0d", k), 1'b1, 25'd102, 1'b0, 2'd1);
      check($sformatf("bp%0d.ready", k), 32'(bus_if.req_ready), 32'h0);
    end
    bus_if.rsp_ready = 1'b1;
    #1 check("bp.release.ready", 32'(bus_if.req_ready), 32'h2);
    tick();
    clear_reqs();
    check_rsp("bp.load", 1'b1, 25'd42, 1'b1, 2'd1);

    // Reset while FULL with requests pending; old pointer would pick req3
    bus_if.rsp_ready = 1'b0;
    set_req(1, 1'b1, 25'd9, 25'd4, 1'b0);
    set_req(3, 1'b1, 25'd1, 25'd1, 1'b0);
    tick();
    check("pre_rst.valid", 32'(bus_if.rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_rsp("midrst", 1'b0, '0, 1'b0, '0);
    check("midrst.ready", 32'(bus_if.req_ready), 32'h0);
    tick();
    check("midrst.hold", 32'(bus_if.rsp_valid), 32'h0);
    rst_n = 1'b1;
    bus_if.rsp_ready = 1'b1;
    #1 check("postrst.ready", 32'(bus_if.req_ready), 32'h2);
    tick();
    clear_reqs();
    check_rsp("postrst", 1'b1, 25'd13, 1'b0, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares a single integer adder-subtractor datapath among `NUM_REQ` requesters, such as PE mantissa/exponent units of the systolic array, using round-robin arbitration and valid/ready handshakes. Each accepted operation is computed in one cycle and held in a single registered response slot. The response carries the requester ID and supports output backpressure. Sustained throughput is one operation per cycle.

## Interface
- `WIDTH`, 25: operand/result width in bits.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `NUM_REQ`: per-requester operation valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high.
- `req_a` in `NUM_REQ*WIDTH`: operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_b` in `NUM_REQ*WIDTH`: operand B, same packing as `req_a`.
- `req_sub` in `NUM_REQ`: 1 = A−B, 0 = A+B.
- `rsp_valid` out 1: response slot holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_sum` out `WIDTH`: result, modulo 2^WIDTH.
- `rsp_cout` out 1: carry out of bit WIDTH−1. For subtraction, 1 means no borrow (A ≥ B unsigned).
- `rsp_id` out `ID_W`: index of the requester that produced the result.

## Operation
- **Slot state:** EMPTY when `rsp_valid`=0, FULL when `rsp_valid`=1.
- **accept** = EMPTY, or FULL with `rsp_ready`=1 (load-while-drain).
- **Grant:** the lowest index j, searching cyclically from `rr_ptr`, with `req_valid[j]`=1. At most one grant per cycle.
  - `req_ready[j]` = grant[j] & accept. All other `req_ready` bits are 0.
  - Handshake at requester j = `req_valid[j]` & `req_ready[j]`.
- **Arithmetic on the granted operands:**
  - sum = A + (B ^ {WIDTH{sub}}) + sub, computed combinationally.
  - cout = carry out of bit WIDTH−1.
- **On handshake:** register sum, cout and j into the slot; `rsp_valid`←1; `rr_ptr`←(j+1) mod NUM_REQ.
- **On rsp_valid & rsp_ready with no new handshake:** `rsp_valid`←0. Data registers hold their values.
- **No handshake:** `rr_ptr` unchanged, so priority does not rotate on idle cycles.
- **Requester rules:** hold `req_valid` and operands stable until `req_ready`. `req_valid` must not depend on `req_ready`.
- **FULL with `rsp_ready`=0:** all `req_ready`=0 and slot contents stable.
- **Reset (any time, including mid-transfer):**
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `rr_ptr`=0.
  - `req_ready`=0 while `rst_n`=0.
  - Any in-flight result is discarded.
- **Fairness:** with every requester continuously valid and `rsp_ready`=1, grants cycle 0,1,…,NUM_REQ−1,0,… Each requester waits at most NUM_REQ−1 grants.

## Timing
- Latency: handshake at edge t → `rsp_valid`=1 with that result from after edge t. The response is visible in cycle t+1.
- Throughput: 1 op/cycle while `rsp_ready`=1.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `rsp_valid` and `rsp_ready`. No other output is combinational from inputs.
- First edge after `rst_n` deasserts: a handshake is possible if a request is valid.

## Structure
- **Package `addsub_arb_pkg`:** `WIDTH` and `NUM_REQ` defaults; `ID_W` function; typedef `op_t` {a, b, sub}; typedef `rsp_t` {sum, cout, id}.
- **Sub-module `rr_picker`:**
  - Parameter `N`; inputs `req[N]` and `ptr`; outputs one-hot `grant[N]`, `gnt_idx`, `any`.
  - Purely combinational, implemented as double-width masked priority.
- **Datapath:** one `CarryLookaheadAdder #(WIDTH)` with B XORed with sub and Cin=sub. There is exactly one adder instance per arbiter.
- The top level holds `rr_ptr`, the response slot registers and the accept logic.

## Test plan
- Reset, then req0 a=5 b=3 sub=1, `rsp_ready`=1 → next cycle `rsp_valid`=1, sum=2, cout=1, id=0.
- req2 a=3 b=5 sub=1 → sum=0x1FFFFFE, cout=0, id=2. Then a=0x1FFFFFF b=1 sub=0 → sum=0, cout=1.
- All four requesters valid continuously, `rsp_ready`=1 → ids 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Slot FULL, `rsp_ready`=0 for 3 cycles with req1 valid → `req_ready`=0 and `rsp_*` stable. Raise `rsp_ready` → drain and req1 accepted in the same cycle, next response id=1.
- Only req3 valid after a grant to req3 → req3 granted again next cycle, and `rr_ptr` wraps to 0.
- Assert `rst_n`=0 while FULL and a request is pending → immediately `rsp_valid`=0, outputs 0. After release, the first grant goes to the lowest valid index.
